// File: rtl/step_controller.sv
// step_controller
//   Turns the timer's square wave into single-cycle step pulses for the
//   processor core. The board RUN and STEP buttons are debounced and drive
//   a RUN / PAUSE / single-STEP state machine that gates the pulses. A
//   free-running counter records how many steps were issued.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synced button level must stay stable (>= 1)
//   COUNT_WIDTH      width of step_count
//
// Ports
//   clock       in   system clock, all logic on posedge
//   reset       in   asynchronous active-high reset, clears all state
//   toggled     in   square wave from timer (same clock domain)
//   run_btn_n   in   raw RUN button, active-low, asynchronous
//   step_btn_n  in   raw STEP button, active-low, asynchronous
//   step        out  one-cycle registered step pulse to the core
//   running     out  high while in RUNNING
//   step_count  out  number of step pulses issued, wraps
module step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 270_000,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   toggled,
    input  logic                   run_btn_n,
    input  logic                   step_btn_n,
    output logic                   step,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] step_count
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PAUSED,
        RUNNING,
        STEP_WAIT
    } state_t;

    state_t                 state_q,       state_d;
    logic                   primed_q,      primed_d;
    logic                   tog_prev_q,    tog_prev_d;
    logic                   run_sync1_q,   run_sync1_d;
    logic                   run_sync2_q,   run_sync2_d;
    logic                   run_stable_q,  run_stable_d;
    logic [DB_W-1:0]        run_cnt_q,     run_cnt_d;
    logic                   step_sync1_q,  step_sync1_d;
    logic                   step_sync2_q,  step_sync2_d;
    logic                   step_stable_q, step_stable_d;
    logic [DB_W-1:0]        step_cnt_q,    step_cnt_d;
    logic                   step_q,        step_d;
    logic [COUNT_WIDTH-1:0] count_q,       count_d;

    logic tick;
    logic run_press;
    logic step_press;
    logic pulse;

    always_comb begin
        // primed stays low for the first cycle after reset release so that
        // a toggled already high at release is not seen as a rising edge
        primed_d   = 1'b1;
        tog_prev_d = toggled;
        tick       = primed_q & toggled & ~tog_prev_q;

        run_sync1_d  = run_btn_n;
        run_sync2_d  = run_sync1_q;
        run_stable_d = run_stable_q;
        run_cnt_d    = '0;
        if (run_sync2_q != run_stable_q) begin
            if (run_cnt_q == DB_LAST) begin
                run_stable_d = run_sync2_q;
            end else begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end
        run_press = run_stable_q & ~run_stable_d;

        step_sync1_d  = step_btn_n;
        step_sync2_d  = step_sync1_q;
        step_stable_d = step_stable_q;
        step_cnt_d    = '0;
        if (step_sync2_q != step_stable_q) begin
            if (step_cnt_q == DB_LAST) begin
                step_stable_d = step_sync2_q;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
        step_press = step_stable_q & ~step_stable_d;

        // run_press has priority over everything else in every state
        state_d = state_q;
        pulse   = 1'b0;
        case (state_q)
            PAUSED: begin
                if (run_press) begin
                    state_d = RUNNING;
                end else if (step_press) begin
                    state_d = STEP_WAIT;
                end
            end
            RUNNING: begin
                if (run_press) begin
                    state_d = PAUSED;
                end else begin
                    pulse = tick;
                end
            end
            STEP_WAIT: begin
                if (run_press) begin
                    state_d = RUNNING;
                    pulse   = tick;
                end else if (tick) begin
                    pulse   = 1'b1;
                    state_d = PAUSED;
                end
            end
            default: state_d = PAUSED;
        endcase

        step_d  = pulse;
        count_d = count_q + COUNT_WIDTH'(pulse);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= PAUSED;
            primed_q      <= 1'b0;
            tog_prev_q    <= 1'b0;
            run_sync1_q   <= 1'b1;
            run_sync2_q   <= 1'b1;
            run_stable_q  <= 1'b1;
            run_cnt_q     <= '0;
            step_sync1_q  <= 1'b1;
            step_sync2_q  <= 1'b1;
            step_stable_q <= 1'b1;
            step_cnt_q    <= '0;
            step_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            primed_q      <= primed_d;
            tog_prev_q    <= tog_prev_d;
            run_sync1_q   <= run_sync1_d;
            run_sync2_q   <= run_sync2_d;
            run_stable_q  <= run_stable_d;
            run_cnt_q     <= run_cnt_d;
            step_sync1_q  <= step_sync1_d;
            step_sync2_q  <= step_sync2_d;
            step_stable_q <= step_stable_d;
            step_cnt_q    <= step_cnt_d;
            step_q        <= step_d;
            count_q       <= count_d;
        end
    end

    assign step       = step_q;
    assign running    = (state_q == RUNNING);
    assign step_count = count_q;

endmodule

// File: tb/tb_step_controller.sv
module tb_step_controller;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          toggled;
    logic          run_btn_n;
    logic          step_btn_n;
    logic          step;
    logic          running;
    logic [CW-1:0] step_count;

    step_controller #(
        .DEBOUNCE_CYCLES(DB),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .toggled   (toggled),
        .run_btn_n (run_btn_n),
        .step_btn_n(step_btn_n),
        .step      (step),
        .running   (running),
        .step_count(step_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef enum logic [1:0] {M_PAUSED, M_RUNNING, M_STEP_WAIT} mstate_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // reference model state
    mstate_t       m_state;
    logic [CW-1:0] m_count;
    bit            m_primed;
    logic          m_tog_prev;
    logic [1:0]    hist_run, hist_step;
    logic          stab_run, stab_step;
    int            cnt_run, cnt_step;

    // stimulus controls
    bit            timer_on;
    int            phase;
    logic          tog_val;
    logic          run_drv, step_drv;
    bit            rel_pending;

    logic [CW-1:0] last_seen = '0;
    bit            saw_zero  = 1'b0;
    bit            saw_wrap  = 1'b0;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = M_PAUSED;
        m_count    = '0;
        m_primed   = 1'b0;
        m_tog_prev = 1'b0;
        hist_run   = 2'b11;
        hist_step  = 2'b11;
        stab_run   = 1'b1;
        stab_step  = 1'b1;
        cnt_run    = 0;
        cnt_step   = 0;
    endtask

    // One clock: drive inputs at negedge, advance the model for the cycle,
    // return 1 time unit after the following posedge.
    task automatic cycle();
        logic syn_r, syn_s, rp, sp, tick, pulse;
        exp_t e;
        @(negedge clock);
        if (rel_pending) begin
            reset       = 1'b0;
            rel_pending = 1'b0;
        end
        if (timer_on) begin
            phase   = (phase + 1) % 6;
            toggled = (phase < 3);
        end else begin
            toggled = tog_val;
        end
        run_btn_n  = run_drv;
        step_btn_n = step_drv;
        if (!reset) begin
            syn_r     = hist_run[1];
            hist_run  = {hist_run[0], run_btn_n};
            syn_s     = hist_step[1];
            hist_step = {hist_step[0], step_btn_n};

            rp = 1'b0;
            if (syn_r != stab_run) begin
                cnt_run++;
                if (cnt_run == DB) begin
                    stab_run = syn_r;
                    cnt_run  = 0;
                    rp       = ~syn_r;
                end
            end else begin
                cnt_run = 0;
            end

            sp = 1'b0;
            if (syn_s != stab_step) begin
                cnt_step++;
                if (cnt_step == DB) begin
                    stab_step = syn_s;
                    cnt_step  = 0;
                    sp        = ~syn_s;
                end
            end else begin
                cnt_step = 0;
            end

            tick       = m_primed && toggled && !m_tog_prev;
            m_primed   = 1'b1;
            m_tog_prev = toggled;

            pulse = 1'b0;
            case (m_state)
                M_PAUSED:    if (rp) m_state = M_RUNNING; else if (sp) m_state = M_STEP_WAIT;
                M_RUNNING:   if (rp) m_state = M_PAUSED; else pulse = tick;
                M_STEP_WAIT: begin
                    if (rp) begin
                        m_state = M_RUNNING;
                        pulse   = tick;
                    end else if (tick) begin
                        pulse   = 1'b1;
                        m_state = M_PAUSED;
                    end
                end
                default:     m_state = M_PAUSED;
            endcase
            if (pulse) begin
                m_count = m_count + 1'b1;
                e.cyc   = cyc + 1;
                e.cnt   = m_count;
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_hold(input logic lvl, input int n);
        run_drv = lvl;
        repeat (n) cycle();
    endtask

    task automatic step_hold(input logic lvl, input int n);
        step_drv = lvl;
        repeat (n) cycle();
    endtask

    // scoreboard: every cycle out of reset, a pulse must appear exactly when
    // one is expected and never otherwise
    always @(posedge clock) begin
        #1;
        if (reset === 1'b0) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                chk("pulse_present", 32'(step), 32'(1));
                chk("pulse_count", 32'(step_count), 32'(mon_e.cnt));
                if (step_count == 0 && last_seen == '1) saw_zero = 1'b1;
                else if (saw_zero && step_count == 1) saw_wrap = 1'b1;
                last_seen = step_count;
            end else begin
                chk("no_pulse", 32'(step), 32'(0));
            end
            chk("running", 32'(running), 32'(m_state == M_RUNNING));
        end
    end

    initial begin
        logic [CW-1:0] saved;
        logic [CW-1:0] want;
        bit            found;

        reset      = 1'b1;
        toggled    = 1'b1;
        run_btn_n  = 1'b1;
        step_btn_n = 1'b1;
        run_drv    = 1'b1;
        step_drv   = 1'b1;
        timer_on   = 1'b0;
        tog_val    = 1'b1;
        phase      = 0;
        rel_pending = 1'b0;
        model_reset();

        repeat (3) cycle();
        chk("rst_step", 32'(step), 32'(0));
        chk("rst_running", 32'(running), 32'(0));
        chk("rst_count", 32'(step_count), 32'(0));

        // release with toggled already high
        phase       = 0;
        timer_on    = 1'b1;
        rel_pending = 1'b1;
        cycle();
        chk("release_no_step", 32'(step), 32'(0));
        repeat (30) cycle();
        chk("paused_count", 32'(step_count), 32'(0));
        chk("paused_running", 32'(running), 32'(0));

        // bounce shorter than the debounce window
        run_hold(1'b0, 3);
        run_hold(1'b1, 2);
        run_hold(1'b0, 3);
        run_hold(1'b1, 10);
        chk("bounce_running", 32'(running), 32'(0));

        // single step with the timer stopped, second press while waiting
        timer_on = 1'b0;
        tog_val  = 1'b0;
        step_hold(1'b0, 8);
        step_hold(1'b1, 8);
        chk("sw_running", 32'(running), 32'(0));
        step_hold(1'b0, 8);
        step_hold(1'b1, 8);
        chk("sw_no_step_yet", 32'(step_count), 32'(0));
        phase    = 5;
        timer_on = 1'b1;
        repeat (20) cycle();
        chk("single_step_count", 32'(step_count), 32'(1));
        chk("single_step_paused", 32'(running), 32'(0));

        // RUN press latency: 2 sync + 4 debounce
        run_drv = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 5) chk("run_latency_early", 32'(running), 32'(0));
            if (i == 6) chk("run_latency", 32'(running), 32'(1));
        end
        run_hold(1'b1, 20);
        chk("run_running", 32'(running), 32'(1));
        chk("run_count", 32'(step_count), 32'(m_count));

        // run_press together with a tick while RUNNING
        for (int i = 0; i < 7 && phase != 0; i++) cycle();
        saved   = m_count;
        run_drv = 1'b0;
        repeat (6) cycle();
        chk("coll_run_state", 32'(running), 32'(0));
        chk("coll_run_nostep", 32'(step), 32'(0));
        chk("coll_run_count", 32'(step_count), 32'(saved));
        run_hold(1'b0, 4);
        run_hold(1'b1, 12);

        // run_press together with a tick while in STEP_WAIT
        timer_on = 1'b0;
        tog_val  = 1'b0;
        step_hold(1'b0, 8);
        step_hold(1'b1, 8);
        saved   = m_count;
        want    = saved + 1'b1;
        run_drv = 1'b0;
        repeat (5) cycle();
        phase    = 5;
        timer_on = 1'b1;
        cycle();
        chk("coll_sw_running", 32'(running), 32'(1));
        chk("coll_sw_step", 32'(step), 32'(1));
        chk("coll_sw_count", 32'(step_count), 32'(want));
        run_hold(1'b0, 4);
        run_hold(1'b1, 12);

        // keep running until the counter wraps 15 -> 0 -> 1
        for (int i = 0; i < 300 && !saw_wrap; i++) cycle();
        chk("wrap_seen", 32'(saw_wrap), 32'(1));
        chk("wrap_count", 32'(step_count), 32'(m_count));

        // reset asserted while step is high
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (step === 1'b1) found = 1'b1;
        end
        chk("pulse_before_reset", 32'(found), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_step", 32'(step), 32'(0));
        chk("rst_mid_running", 32'(running), 32'(0));
        chk("rst_mid_count", 32'(step_count), 32'(0));
        chk("sb_drained", 32'(sb.size()), 32'(0));
        sb.delete();
        model_reset();
        repeat (3) cycle();
        chk("rst_hold_count", 32'(step_count), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
